// File: rtl/ex_pkg.sv
// ex_pkg
// Shared definitions for the ID/EX issue stage: ALUOp encodings,
// RV32I opcode constants, the issue-entry record held by the skid
// buffer, and the skid-buffer state encoding.
// No ports (package).
package ex_pkg;

    localparam int EX_XLEN = 32;
    localparam int EX_RD_W = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic [EX_XLEN-1:0] a;
        logic [EX_XLEN-1:0] b;
        logic [3:0]         aluOp;
        logic [EX_RD_W-1:0] rd;
        logic               regWrite;
        logic               illegal;
    } issue_entry_t;

    localparam int ISSUE_ENTRY_W = $bits(issue_entry_t);

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_t;

    // Shared funct3 -> ALUOp map for R-type and I-ALU; alt picks the
    // SUB/SRA variant on the two funct3 values that have one.
    function automatic logic [3:0] f3ToAluOp(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000: op = alt ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_issue_stage_decode.sv
// alu_op_decode
// Purely combinational decode of opcode/funct3/funct7[5] into the ALU
// control word and operand selects.
// Ports:
//   opcode, funct3, funct7_5 : instruction fields
//   aluOp                    : 4-bit ALU control
//   aZero                    : operand A is zero instead of rs1
//   bImm                     : operand B is the immediate instead of rs2
//   regWrite                 : instruction writes rd (before rd==0 masking)
//   illegal                  : unsupported opcode or funct combination
module alu_op_decode
    import ex_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] aluOp,
    output logic       aZero,
    output logic       bImm,
    output logic       regWrite,
    output logic       illegal
);

    // Defaults describe the "unsupported instruction" shape (ADD of rs1
    // and imm, no writeback); each legal opcode overrides what differs.
    // An R-type with funct7[5] set on a funct3 that has no alternate
    // form falls back to that same illegal shape.
    always_comb begin
        aluOp    = ALU_ADD;
        aZero    = 1'b0;
        bImm     = 1'b1;
        regWrite = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
                    illegal = 1'b1;
                end else begin
                    aluOp    = f3ToAluOp(funct3, funct7_5);
                    bImm     = 1'b0;
                    regWrite = 1'b1;
                end
            end
            OP_IMM: begin
                aluOp    = f3ToAluOp(funct3, funct7_5 && (funct3 == 3'b101));
                regWrite = 1'b1;
            end
            OP_LOAD: begin
                regWrite = 1'b1;
            end
            OP_STORE: begin
                regWrite = 1'b0;
            end
            OP_BRANCH: begin
                aluOp = ALU_SUB;
                bImm  = 1'b0;
            end
            OP_LUI: begin
                aZero    = 1'b1;
                regWrite = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ex_issue_stage.sv
// ex_issue_stage
// ID/EX stage in front of the ALU. Decodes the incoming instruction,
// selects operands and registers the result through a 2-entry skid
// buffer so that in_ready is a flop and EX stalls never reach ID
// combinationally.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : drop every buffered entry and any same-cycle input
//   in_valid/in_ready   : upstream handshake (in_ready registered)
//   in_opcode..in_rd    : decoded instruction fields and operand values
//   out_valid/out_ready : downstream handshake to the ALU
//   out_A, out_B        : ALU operands
//   out_ALUOp           : ALU control
//   out_rd              : destination index
//   out_reg_write       : result writes rd (never for rd==0)
//   out_illegal         : unsupported opcode/funct
module ex_issue_stage
    import ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_5,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_A,
    output logic [XLEN-1:0] out_B,
    output logic [3:0]      out_ALUOp,
    output logic [RD_W-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      aluOp;
        logic [RD_W-1:0] rd;
        logic            regWrite;
        logic            illegal;
    } entry_t;

    skid_state_t state, nextState;
    entry_t      mainEntry, skidEntry, newEntry;
    logic        inReadyReg;
    logic        accept, consume;
    logic        loadMainNew, loadMainSkid, loadSkid;
    logic [3:0]  decAluOp;
    logic        decAZero, decBImm, decRegWrite, decIllegal;

    alu_op_decode uDecode (
        .opcode   (in_opcode),
        .funct3   (in_funct3),
        .funct7_5 (in_funct7_5),
        .aluOp    (decAluOp),
        .aZero    (decAZero),
        .bImm     (decBImm),
        .regWrite (decRegWrite),
        .illegal  (decIllegal)
    );

    assign accept    = in_valid && inReadyReg;
    assign consume   = out_valid && out_ready;
    assign in_ready  = inReadyReg;
    assign out_valid = (state != SKID_EMPTY);

    // Build the entry that would be captured this cycle; writes to x0
    // are suppressed here so EX never sees a reg_write for rd==0.
    always_comb begin
        newEntry          = '0;
        newEntry.a        = decAZero ? '0 : in_rs1_data;
        newEntry.b        = decBImm ? in_imm : in_rs2_data;
        newEntry.aluOp    = decAluOp;
        newEntry.rd       = in_rd;
        newEntry.regWrite = decRegWrite && (in_rd != '0);
        newEntry.illegal  = decIllegal;
    end

    // Skid-buffer control. Main always holds the oldest entry; skid only
    // fills when main is stalled and a new entry arrives. Flush wins over
    // accept and consume and simply empties the buffer.
    always_comb begin
        nextState    = state;
        loadMainNew  = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        if (flush) begin
            nextState = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        nextState   = SKID_ONE;
                        loadMainNew = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (accept && consume) begin
                        loadMainNew = 1'b1;
                    end else if (accept) begin
                        nextState = SKID_FULL;
                        loadSkid  = 1'b1;
                    end else if (consume) begin
                        nextState = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (consume) begin
                        nextState    = SKID_ONE;
                        loadMainSkid = 1'b1;
                    end
                end
                default: nextState = SKID_EMPTY;
            endcase
        end
    end

    // State register. in_ready is registered from the next state so it
    // is low exactly while the buffer is full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SKID_EMPTY;
            inReadyReg <= 1'b1;
        end else begin
            state      <= nextState;
            inReadyReg <= (nextState != SKID_FULL);
        end
    end

    // Entry storage. Main resets to an idle ADD so the ALU inputs are
    // defined out of reset; contents left behind by a flush are harmless
    // because out_valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mainEntry       <= '0;
            mainEntry.aluOp <= ALU_ADD;
            skidEntry       <= '0;
        end else begin
            if (loadMainNew) begin
                mainEntry <= newEntry;
            end else if (loadMainSkid) begin
                mainEntry <= skidEntry;
            end
            if (loadSkid) begin
                skidEntry <= newEntry;
            end
        end
    end

    assign out_A         = mainEntry.a;
    assign out_B         = mainEntry.b;
    assign out_ALUOp     = mainEntry.aluOp;
    assign out_rd        = mainEntry.rd;
    assign out_reg_write = mainEntry.regWrite;
    assign out_illegal   = mainEntry.illegal;

endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Accepts a decoded RV32I instruction (opcode, funct3, funct7[5], register operands, immediate, rd).
- Selects the ALU operands and produces the 4-bit ALUOp.
- Registers everything through a 2-entry skid buffer with valid/ready handshakes on both sides. in_ready is registered, so stalls from EX never combinationally reach ID.

Parameters:
XLEN, 32, operand/result width
RD_W, 5, destination register index width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
flush  in  1  kill all buffered entries (branch mispredict/trap)
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept; registered
in_opcode  in  7  instr[6:0]
in_funct3  in  3  instr[14:12]
in_funct7_5  in  1  instr[30]
in_rs1_data  in  XLEN  rs1 value
in_rs2_data  in  XLEN  rs2 value
in_imm  in  XLEN  sign-extended immediate, already formatted by decoder
in_rd  in  RD_W  destination index
out_valid  out  1  entry presented to ALU
out_ready  in  1  EX consumes entry
out_A  out  XLEN  ALU operand A
out_B  out  XLEN  ALU operand B
out_ALUOp  out  4  ALU control
out_rd  out  RD_W  destination index
out_reg_write  out  1  result writes rd (forced 0 when rd==0)
out_illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset: synchronous, active-low; clk is the only clock. While rst_n=0 at a rising edge, both entries are invalidated. Reset values:
  - out_valid=0, in_ready=1, out_illegal=0, out_reg_write=0.
  - out_A, out_B, out_rd = 0.
  - out_ALUOp=4'b0010.
  - Reset mid-stall discards both entries.
- ALUOp encoding: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000, SLTU 1001.
- Decode, combinational on in_*, captured at accept:
  - R-type 0110011: A=rs1, B=rs2, reg_write=1.
    - f3=000: ADD, or SUB if f7_5=1.
    - f3=001: SLL. f3=010: SLT. f3=011: SLTU. f3=100: XOR.
    - f3=101: SRL, or SRA if f7_5=1.
    - f3=110: OR. f3=111: AND.
    - f7_5=1 with any f3 other than 000/101 is illegal.
  - I-ALU 0010011: A=rs1, B=imm, same f3 map as R-type.
    - f7_5 selects SRA only for f3=101; it is ignored for f3=000 (always ADD).
    - reg_write=1.
  - LOAD 0000011: ADD, A=rs1, B=imm, reg_write=1.
  - STORE 0100011: ADD, A=rs1, B=imm, reg_write=0.
  - BRANCH 1100011: SUB, A=rs1, B=rs2, reg_write=0.
  - LUI 0110111: ADD, A=0, B=imm, reg_write=1.
  - Any other opcode: illegal=1, ALUOp=ADD, A=rs1, B=imm, reg_write=0.
  - reg_write is forced 0 when rd==0.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_* are stable while out_valid && !out_ready.
- Skid buffer, states EMPTY, ONE (main valid), FULL (main+skid valid):
  - EMPTY + accept → ONE. Latency is 1 cycle: accepted at edge N, out_valid=1 after edge N.
  - ONE + accept + consume → ONE; main is reloaded with the new entry.
  - ONE + accept, no consume → FULL; the new entry goes to skid; in_ready=0 next cycle.
  - ONE + consume only → EMPTY.
  - FULL + consume → ONE; skid moves to main; in_ready=1 next cycle.
  - FULL: in_valid is ignored (in_ready=0).
- Order is strictly FIFO. No entry is dropped or duplicated.
- flush=1 at an edge:
  - Next state is EMPTY, in_ready=1, out_valid=0.
  - Any in_valid presented the same cycle is discarded.
  - flush has priority over accept and consume; reset has priority over flush.
- Throughput: 1 entry/cycle when out_ready is held 1.

Decomposition:
- Shared package ex_pkg:
  - ALUOp localparams (ALU_AND … ALU_SLTU).
  - Opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI).
  - Packed issue-entry struct/width constant.
- Sub-module alu_op_decode: purely combinational; opcode/f3/f7_5 → ALUOp, operand selects, reg_write, illegal.
- Top holds the skid-buffer registers and FSM.

Test Plan:
- Reset, then R-type f3=000 f7_5=0, rs1=10, rs2=10, rd=5, out_ready=1 → next cycle out_valid=1, A=10, B=10, ALUOp=0010, reg_write=1.
- R-type f3=000 f7_5=1, rs1=30, rs2=10 → ALUOp=0110, A=30, B=10. I-ALU f3=111 with rs1=0x3FFFC, imm=7 → ALUOp=0000, B=7.
- Backpressure:
  - out_ready=0; push entries E1 (rd=1) then E2 (rd=2) → in_ready=0 after the second accept; out holds E1 stable.
  - Raise out_ready → E1 then E2 on consecutive cycles; in_ready=1 again.
- flush while FULL with in_valid=1 (rd=3) → next cycle out_valid=0, in_ready=1; rd=3 never appears.
- Branch rs1=5, rs2=5, rd=0 → ALUOp=0110, reg_write=0. LUI imm=0x12345000 → A=0, B=0x12345000. I-ALU rd=0 → reg_write=0.
- Opcode 1111111 → out_illegal=1, ALUOp=0010, reg_write=0. Assert rst_n=0 while FULL → next cycle out_valid=0, in_ready=1.
